// File: rtl/imap_fetch_ctrl_if.sv
// Arbiter command/response bus and PE-input stream of the IMAP fetch sequencer.
// master = sequencer side, slave = arbiter / consumer side.
interface imap_fetch_ctrl_if;
  logic        biu2arb_req;
  logic [31:0] biu2arb_addr;
  logic        biu2arb_vld;
  logic        biu2arb_rdy;
  logic [31:0] arb2biu_data;
  logic        arb2biu_vld;
  logic        arb2biu_rdy;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_rdy;

  modport master (
    output biu2arb_req, biu2arb_addr, biu2arb_vld, arb2biu_rdy, dout, dout_vld,
    input  biu2arb_rdy, arb2biu_data, arb2biu_vld, dout_rdy
  );

  modport slave (
    input  biu2arb_req, biu2arb_addr, biu2arb_vld, arb2biu_rdy, dout, dout_vld,
    output biu2arb_rdy, arb2biu_data, arb2biu_vld, dout_rdy
  );
endinterface

// File: rtl/imap_fetch_ctrl.sv
// Purpose: fetch len words from the ICB arbiter into a local FIFO and stream them to the PE array.
// Latency: first command one cycle after start, data leaves the FIFO one cycle after its response.
// Backpressure: dout_rdy stalls the FIFO; issue is credit-limited since responses cannot be stalled.
module imap_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

module imap_fetch_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  imap_fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, issued_q, received_q;
  logic [31:0]      addr_q;
  logic             cmd_vld, cmd_fire, resp_rdy, push, pop;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      fifo_head;
  logic [LEN_W:0]   credit_used;

  // In-flight commands plus buffered words may never exceed the FIFO capacity.
  assign credit_used = {1'b0, issued_q - received_q} + (LEN_W+1)'(fifo_count);
  assign cmd_vld     = (state_q == S_REQ) && (issued_q != len_q) &&
                       (credit_used < (LEN_W+1)'(FIFO_DEPTH));
  assign cmd_fire    = cmd_vld & bus.biu2arb_rdy;
  assign resp_rdy    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign push        = bus.arb2biu_vld & resp_rdy;
  assign pop         = !fifo_empty & bus.dout_rdy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_REQ : S_DONE;
      S_REQ:   if (cmd_fire && (issued_q + LEN_W'(1) == len_q)) state_d = S_DRAIN;
      S_DRAIN: if (received_q == len_q) state_d = S_FLUSH;
      S_FLUSH: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start && len != '0) begin
        len_q      <= len;
        addr_q     <= {base_addr[31:2], 2'b00};
        issued_q   <= '0;
        received_q <= '0;
      end else begin
        if (cmd_fire) begin
          addr_q   <= addr_q + 32'd4;
          issued_q <= issued_q + LEN_W'(1);
        end
        if (push) received_q <= received_q + LEN_W'(1);
      end
    end
  end

  imap_sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (bus.arb2biu_data),
    .pop      (pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The grant is held through DRAIN: the arbiter discards responses once req drops.
  assign bus.biu2arb_req  = resp_rdy;
  assign bus.biu2arb_addr = addr_q;
  assign bus.biu2arb_vld  = cmd_vld;
  assign bus.arb2biu_rdy  = resp_rdy;
  assign bus.dout_vld     = !fifo_empty;
  assign bus.dout         = fifo_empty ? 32'd0 : fifo_head;
  assign busy             = (state_q == S_REQ) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign done             = (state_q == S_DONE);
endmodule

// File: doc/imap_fetch_ctrl.md
Name: imap_fetch_ctrl

Overview:
- Read-fetch sequencer for the input-feature-map BIU, sitting between the accelerator control FSM and the shared ICB arbiter port (`imap_biu2arb_*` / `arb2imap_biu_*`).
- On `start`, it requests the arbiter, issues `len` consecutive word reads from `base_addr` and buffers the returned data in a local FIFO.
- It streams the buffered words to the PE-array input buffer over a valid/ready port, then pulses `done`.
- Issue is credit-limited so the FIFO can never overflow. This matters because the arbiter's response path cannot be back-pressured.

Parameters:
- FIFO_DEPTH, 8, response buffer depth in 32-bit words; power of two, minimum 2.
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; launches a fetch when idle
- base_addr  in  32  byte address of first word; bits [1:0] ignored (treated as 0)
- len  in  LEN_W  number of 32-bit words to fetch
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last word has left the FIFO
- biu2arb_req  out  1  arbitration request to arbiter
- biu2arb_addr  out  32  read address
- biu2arb_vld  out  1  command valid
- biu2arb_rdy  in  1  grant/ready from arbiter
- arb2biu_data  in  32  read response data
- arb2biu_vld  in  1  response valid
- arb2biu_rdy  out  1  response ready
- dout  out  32  data to PE input buffer
- dout_vld  out  1  data valid
- dout_rdy  in  1  consumer ready

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All state is cleared to IDLE, counters and FIFO pointers to 0, and every output is 0 (including `dout`).
- States:
  - IDLE, REQ, DRAIN, FLUSH, DONE, encoded one-hot or binary as convenient.
  - IDLE: `start` with `len != 0` latches `len` and `base_addr & ~3`, then goes to REQ. `start` with `len == 0` goes straight to DONE. `start` in any other state is ignored.
  - REQ: `biu2arb_req` = 1. A command is accepted on `biu2arb_vld & biu2arb_rdy`. Each acceptance adds 4 to the address and increments `issued`. Once `issued == len` after an acceptance, go to DRAIN.
  - DRAIN: `biu2arb_req` stays 1 and `biu2arb_vld` = 0 until `received == len`, then go to FLUSH. `req` must not drop while responses are outstanding, because the arbiter discards responses once the grant is released.
  - FLUSH: `req` = 0. Wait until the FIFO is empty, then go to DONE.
  - DONE: `done` = 1 for one cycle, `busy` = 0 in this cycle, then go to IDLE.
- `busy` = 1 in REQ, DRAIN and FLUSH.
- The arbiter's grant latency is at least 2 cycles after `req` rises. Before grant, `biu2arb_rdy` is 0 and commands wait. `biu2arb_addr` and `biu2arb_vld` hold stable while `vld & !rdy`.
- Credit rule:
  - `biu2arb_vld` = 1 only in REQ, with `issued < len` and `(issued − received) + fifo_count < FIFO_DEPTH`.
  - The outstanding count uses registered counters. Because of that, a response and an issue in the same cycle are both counted correctly next cycle.
- Response acceptance:
  - `arb2biu_rdy` = 1 in REQ and DRAIN.
  - A response is written to the FIFO on `arb2biu_vld & arb2biu_rdy`, incrementing `received`.
  - Responses arriving in IDLE, FLUSH or DONE are dropped, with `arb2biu_rdy` = 0.
- FIFO:
  - First-word fall-through: `dout` and `dout_vld` are driven from the head entry, with `dout_vld` = !empty.
  - A pop happens on `dout_vld & dout_rdy`.
  - A simultaneous push and pop leaves the count unchanged. On a full FIFO, a push with a pop is legal.
  - The credit rule guarantees that a push never occurs into a full FIFO without a pop. Verification asserts this.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters are LEN_W bits wide. `len` = 2^LEN_W − 1 must complete without wrap, and the address wraps modulo 2^32.
- `arb2biu_data` is taken as-is. Bus error is not visible on this interface and is not handled.
- Reset mid-operation: abort immediately, flush the FIFO, drop `req`, and generate no `done`.

Test Plan:
- `base_addr` = 0x1000_0000, `len` = 4, arbiter grants after 2 cycles, responses 1 cycle after each command, `dout_rdy` = 1 → addresses 0x1000_0000/04/08/0C are issued in order, 4 words are output in order, one `done` pulse follows, and `req` falls only after the 4th response.
- `len` = 20, `dout_rdy` = 0 for 30 cycles, then 1 → at most 8 commands are outstanding plus buffered, there is no overflow, all 20 words are delivered in order, and there is one `done`.
- `len` = 0 → `done` pulses the cycle after `start`, `biu2arb_req` never asserts, and `busy` stays 0.
- Grant withheld for 10 cycles (`biu2arb_rdy` = 0) with `vld` high → `addr` is stable at `base_addr`, no acceptance is counted, and a normal completion follows after grant.
- `base_addr` = 0xFFFF_FFF8, `len` = 3 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 are issued and `done` follows.
- `rst_n` low for 1 cycle while 3 of 6 words are outstanding → all outputs are 0 the next cycle, and a new `start` with `len` = 2 completes cleanly with 2 words and one `done`.
